// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: global enable, one byte-masked write port,
// NRD read ports and the busy flag. The master drives requests; the slave is the register file.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NRD    = 2
);
  logic                    en;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [DATA_W/8-1:0]     wr_be;
  logic [NRD-1:0]          rd_en;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*DATA_W-1:0]   rd_data;
  logic [NRD-1:0]          rd_valid;
  logic                    busy;

  modport master (
    output en, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );
  modport slave (
    input  en, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file: zero-fills itself after reset, then serves one
// byte-masked write and NRD independent 1-cycle reads per clock.

module reg_file_mp_rdport #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept_i,
  input  logic              inr_i,
  input  logic              byp_i,
  input  logic [DATA_W-1:0] mem_word_i,
  input  logic [DATA_W-1:0] merged_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q;

  always_comb begin
    data_d = data_q;
    if (accept_i) data_d = !inr_i ? '0 : (byp_i ? merged_i : mem_word_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= accept_i;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = vld_q;
endmodule

module reg_file_mp #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input logic           clk,
  input logic           rst,
  reg_file_mp_if.slave  bus
);
  localparam int         NBYTE   = DATA_W / 8;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run, wr_inr, wr_ok;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_old, wr_merged;

  logic [NRD-1:0][ADDR_W-1:0] rd_addr;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0]             rd_valid;

  assign run           = (state_q == S_RUN);
  assign bus.busy      = ~run;
  assign rd_addr       = bus.rd_addr;
  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;

  // Clear walker: one entry per enabled edge, hands over to RUN on the last one.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (bus.en && !run) begin
      if (ptr_q == ADDR_W'(DEPTH - 1)) begin
        state_d = S_RUN;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Out-of-range and hardwired-zero addresses are folded onto index 0 and masked.
  assign wr_inr = (32'(bus.wr_addr) < 32'(DEPTH)) && !((ZERO_R0 != 0) && (bus.wr_addr == '0));
  assign wr_idx = wr_inr ? bus.wr_addr : '0;
  assign wr_old = mem_q[wr_idx];
  assign wr_ok  = run && bus.en && bus.wr_en && wr_inr;

  always_comb begin
    wr_merged = wr_old;
    for (int k = 0; k < NBYTE; k++)
      if (bus.wr_be[k]) wr_merged[8*k +: 8] = bus.wr_data[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (bus.en && !run) mem_q[ptr_q]  <= '0;
    else if (wr_ok)     mem_q[wr_idx] <= wr_merged;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic              inr;
    logic [ADDR_W-1:0] idx;

    assign inr = (32'(rd_addr[p]) < 32'(DEPTH)) && !((ZERO_R0 != 0) && (rd_addr[p] == '0));
    assign idx = inr ? rd_addr[p] : '0;

    reg_file_mp_rdport #(.DATA_W(DATA_W)) u_rd (
      .clk        (clk),
      .rst        (rst),
      .accept_i   (run && bus.en && bus.rd_en[p]),
      .inr_i      (inr),
      .byp_i      ((BYPASS != 0) && wr_ok && (bus.wr_addr == rd_addr[p])),
      .mem_word_i (mem_q[idx]),
      .merged_i   (wr_merged),
      .rd_data_o  (rd_data[p]),
      .rd_valid_o (rd_valid[p])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default build, a no-bypass build and a
// DEPTH=12 / ZERO_R0 build all share one stimulus stream.
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en, wr_en;
  logic [3:0]  wr_addr, wr_be;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [3:0]  ra0, ra1;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(4), .NRD(2)) if0 ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(4), .NRD(2)) if1 ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(4), .NRD(2)) if2 ();

  assign if0.en = en; assign if0.wr_en = wr_en; assign if0.wr_addr = wr_addr; assign if0.wr_data = wr_data;
  assign if0.wr_be = wr_be; assign if0.rd_en = rd_en; assign if0.rd_addr = {ra1, ra0};
  assign if1.en = en; assign if1.wr_en = wr_en; assign if1.wr_addr = wr_addr; assign if1.wr_data = wr_data;
  assign if1.wr_be = wr_be; assign if1.rd_en = rd_en; assign if1.rd_addr = {ra1, ra0};
  assign if2.en = en; assign if2.wr_en = wr_en; assign if2.wr_addr = wr_addr; assign if2.wr_data = wr_data;
  assign if2.wr_be = wr_be; assign if2.rd_en = rd_en; assign if2.rd_addr = {ra1, ra0};

  reg_file_mp #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .NRD(2), .BYPASS(1), .ZERO_R0(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  reg_file_mp #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .NRD(2), .BYPASS(0), .ZERO_R0(0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  reg_file_mp #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .NRD(2), .BYPASS(1), .ZERO_R0(1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [1:0]  re;
    logic [3:0]  a0, a1;
    logic [1:0]  ev;
    logic [31:0] e0, e1;   // BYPASS=1 expected port0/port1
    logic [31:0] n0, n1;   // BYPASS=0 expected port0/port1
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be,
                       input logic [1:0] re, input logic [3:0] a0, input logic [3:0] a1);
    wr_en = w; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; ra0 = a0; ra1 = a1;
  endtask

  initial begin
    int b0, b2;
    logic seen;

    tbl[0]  = '{1'b1, 4'd0,  32'hABCDEFAB, 4'hF, 2'b00, 4'd0, 4'd0,  2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 4'd1,  32'h01234567, 4'hF, 2'b00, 4'd0, 4'd0,  2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b11, 4'd0, 4'd1,  2'b11, 32'hABCDEFAB, 32'h01234567, 32'hABCDEFAB, 32'h01234567};
    tbl[3]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b00, 4'd0, 4'd1,  2'b00, 32'hABCDEFAB, 32'h01234567, 32'hABCDEFAB, 32'h01234567};
    tbl[4]  = '{1'b1, 4'd3,  32'h11223344, 4'hF, 2'b00, 4'd0, 4'd0,  2'b00, 32'hABCDEFAB, 32'h01234567, 32'hABCDEFAB, 32'h01234567};
    tbl[5]  = '{1'b1, 4'd3,  32'hAABBCCDD, 4'h5, 2'b11, 4'd3, 4'd3,  2'b11, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 32'h11223344};
    tbl[6]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b01, 4'd3, 4'd0,  2'b01, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344};
    tbl[7]  = '{1'b1, 4'd1,  32'hFFFFFFFF, 4'h0, 2'b10, 4'd0, 4'd1,  2'b10, 32'h11BB33DD, 32'h01234567, 32'h11BB33DD, 32'h01234567};
    tbl[8]  = '{1'b1, 4'd2,  32'h5A000000, 4'h8, 2'b11, 4'd2, 4'd0,  2'b11, 32'h5A000000, 32'hABCDEFAB, 32'h00000000, 32'hABCDEFAB};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b11, 4'd2, 4'd15, 2'b11, 32'h5A000000, 32'h0, 32'h5A000000, 32'h0};
    tbl[10] = '{1'b1, 4'd15, 32'hFFFFFFFF, 4'h3, 2'b11, 4'd15, 4'd15, 2'b11, 32'h0000FFFF, 32'h0000FFFF, 32'h0, 32'h0};

    en = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'd0, 4'd1);
    #1 rst = 1'b1;
    #1;
    chk("reset busy",     64'(if0.busy),     64'd1);
    chk("reset rd_valid", 64'(if0.rd_valid), 64'd0);
    chk("reset rd_data",  if0.rd_data,       64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Initial clear with rd_en held high: valid must never rise while busy.
    b0 = 0; b2 = 0; seen = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (if0.busy && if0.rd_valid != 2'b00) seen = 1'b1;
      if (b0 == 0 && !if0.busy) b0 = k;
      if (b2 == 0 && !if2.busy) b2 = k;
      if (b0 != 0 && b2 != 0) break;
    end
    chk("clear edges dut0",    64'(b0), 64'd16);
    chk("clear edges depth12", 64'(b2), 64'd12);
    chk("rd_valid during clear", 64'(seen), 64'd0);

    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'(2*a), 4'(2*a+1));
      step();
      chk($sformatf("post-clear read %0d/%0d", 2*a, 2*a+1), {if0.rd_data, 30'd0, if0.rd_valid},
          {64'd0, 30'd0, 2'b11});
    end

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].a0, tbl[i].a1);
      step();
      chk($sformatf("t%0d byp valid", i), 64'(if0.rd_valid), 64'(tbl[i].ev));
      chk($sformatf("t%0d byp data", i),  if0.rd_data, {tbl[i].e1, tbl[i].e0});
      chk($sformatf("t%0d nobyp valid", i), 64'(if1.rd_valid), 64'(tbl[i].ev));
      chk($sformatf("t%0d nobyp data", i),  if1.rd_data, {tbl[i].n1, tbl[i].n0});
    end

    // en=0: write and reads both dropped, outputs hold.
    en = 1'b0;
    drive(1'b1, 4'd0, 32'h0, 4'hF, 2'b11, 4'd0, 4'd1);
    step();
    chk("en0 valid", 64'(if0.rd_valid), 64'd0);
    chk("en0 data",  if0.rd_data, {32'h0000FFFF, 32'h0000FFFF});
    en = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'd0, 4'd1);
    step();
    chk("en0 array kept", if0.rd_data, {32'h01234567, 32'hABCDEFAB});

    // DEPTH=12 / ZERO_R0 build: entry 0 and out-of-range addresses read zero.
    drive(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 2'b00, 4'd0, 4'd0);
    step();
    drive(1'b1, 4'd13, 32'h12345678, 4'hF, 2'b11, 4'd0, 4'd13);
    step();
    chk("r0/oor valid", 64'(if2.rd_valid), 64'd3);
    chk("r0/oor data",  if2.rd_data, 64'd0);
    drive(1'b1, 4'd11, 32'hCAFEBABE, 4'hF, 2'b11, 4'd11, 4'd13);
    step();
    chk("last entry bypass", if2.rd_data, {32'h0, 32'hCAFEBABE});
    drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b01, 4'd11, 4'd0);
    step();
    chk("last entry stored", {if2.rd_data, 30'd0, if2.rd_valid}, {32'h0, 32'hCAFEBABE, 30'd0, 2'b01});

    // Asynchronous reset mid-cycle from RUN.
    rst = 1'b1;
    #1;
    chk("async rst dut0 data",  if0.rd_data, 64'd0);
    chk("async rst dut2 data",  if2.rd_data, 64'd0);
    chk("async rst busy/valid", {62'd0, if0.busy, |if0.rd_valid}, {62'd0, 2'b10});
    #1 rst = 1'b0;

    // Restart at clear step 7, then stall en for 3 edges mid-clear.
    drive(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 2'b11, 4'd0, 4'd5);
    repeat (7) step();
    rst = 1'b1;
    #2 rst = 1'b0;
    b0 = 0; b2 = 0; seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      en = !(k >= 4 && k <= 6);
      step();
      if (if0.busy && if0.rd_valid != 2'b00) seen = 1'b1;
      if (b0 == 0 && !if0.busy) b0 = k;
      if (b2 == 0 && !if2.busy) b2 = k;
      if (b0 != 0 && b2 != 0) break;
    end
    en = 1'b1;
    chk("restart+stall edges dut0",    64'(b0), 64'd19);
    chk("restart+stall edges depth12", 64'(b2), 64'd15);
    chk("rd_valid during restart",     64'(seen), 64'd0);

    drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'd0, 4'd3);
    step();
    chk("re-cleared dut0", {if0.rd_data, 30'd0, if0.rd_valid}, {64'd0, 30'd0, 2'b11});
    drive(1'b0, 4'd0, 32'h0, 4'h0, 2'b11, 4'd11, 4'd2);
    step();
    chk("re-cleared depth12", {if2.rd_data, 30'd0, if2.rd_valid}, {64'd0, 30'd0, 2'b11});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
